// File: rtl/prio_req_pkg.sv
// Shared types and helpers for the registered priority request encoder.
package prio_req_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } prio_state_t;

    // Index width for n request lines, never less than one bit
    function automatic int unsigned clog2_min1(input int unsigned n);
        int unsigned r;
        r = 1;
        while ((32'd1 << r) < n) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/prio_find_msb.sv
// Combinational highest-set-bit finder; idx is 0 when vec is empty.
module prio_find_msb
    import prio_req_pkg::*;
#(
    parameter int unsigned N = 8,
    localparam int unsigned W = clog2_min1(N)
) (
    input  logic [N-1:0] vec,
    output logic [W-1:0] idx,
    output logic         any
);

    // Scan upward so the highest set index is the last one written
    always_comb begin
        idx = '0;
        any = |vec;
        for (int i = 0; i < N; i++) begin
            if (vec[i]) begin
                idx = W'(i);
            end
        end
    end

endmodule

// File: rtl/prio_req_encoder.sv
// Registered strict-priority request encoder with sticky pending bits,
// valid/ready grant handshake and a saturating lost-request counter.
// Optional build macro PRIO_REQ_MASK_EN adds a mask input that hides
// pending bits from selection without stopping them from latching.
module prio_req_encoder
    import prio_req_pkg::*;
#(
    parameter int unsigned N     = 8,
    parameter int unsigned CNT_W = 4,
    localparam int unsigned W    = clog2_min1(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N-1:0]     Din,
    output logic [W-1:0]     Dout,
    output logic             Dvalid,
    input  logic             Dready,
`ifdef PRIO_REQ_MASK_EN
    input  logic [N-1:0]     mask,
`endif
    output logic [N-1:0]     pending,
    output logic [CNT_W-1:0] lost_cnt
);

    prio_state_t       state;
    prio_state_t       state_next;
    logic [N-1:0]      eligible;
    logic [N-1:0]      clr;
    logic [N-1:0]      pend_next;
    logic [W-1:0]      winner;
    logic              win_any;
    logic [W-1:0]      dout_next;
    logic              dvalid_next;
    logic [CNT_W-1:0]  lost_next;

    // Requests that may compete for the next grant
    always_comb begin
`ifdef PRIO_REQ_MASK_EN
        eligible = pending & ~mask;
`else
        eligible = pending;
`endif
    end

    prio_find_msb #(
        .N (N)
    ) u_find_msb (
        .vec (eligible),
        .idx (winner),
        .any (win_any)
    );

    // Next-state, pending update and collision counting
    always_comb begin
        state_next  = state;
        dout_next   = Dout;
        dvalid_next = Dvalid;
        clr         = '0;
        lost_next   = lost_cnt;

        if ((state == GRANT) && Dready) begin
            clr = N'(1) << Dout;
        end

        // A new pulse on the bit being accepted re-arms it (set beats clear)
        pend_next = (pending & ~clr) | Din;

        if ((|(Din & pending & ~clr)) && !(&lost_cnt)) begin
            lost_next = lost_cnt + CNT_W'(1);
        end

        case (state)
            IDLE: begin
                if (win_any) begin
                    dout_next   = winner;
                    dvalid_next = 1'b1;
                    state_next  = GRANT;
                end
            end
            GRANT: begin
                if (Dready) begin
                    dvalid_next = 1'b0;
                    state_next  = IDLE;
                end
            end
            default: begin
                dvalid_next = 1'b0;
                state_next  = IDLE;
            end
        endcase
    end

    // State and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            Dout     <= '0;
            Dvalid   <= 1'b0;
            pending  <= '0;
            lost_cnt <= '0;
        end else begin
            state    <= state_next;
            Dout     <= dout_next;
            Dvalid   <= dvalid_next;
            pending  <= pend_next;
            lost_cnt <= lost_next;
        end
    end

endmodule

// File: doc/prio_req_encoder.md
Name: prio_req_encoder

Overview:
- Parametrised, registered successor to the team's combinational 8-to-3 priority encoder.
- Captures request pulses on an N-bit vector into a sticky pending register. Presents the highest-index pending request as a binary code with a valid/ready handshake, and clears that request on acceptance.
- Counts requests lost because their bit was already pending.
- Sits between interrupt/event sources and a single consumer, for example a controller FSM.

Parameters:
- N, 8, number of request lines; must be at least 2.
- CNT_W, 4, width of the saturating lost-request counter.
- W, $clog2(N), localparam; width of Dout.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- Din  input  N  request pulses, sampled every clk edge; bit i is request i.
- Dout  output  W  index of the granted request, registered.
- Dvalid  output  1  Dout holds a valid grant.
- Dready  input  1  consumer accepts the grant when Dvalid is high.
- pending  output  N  current sticky pending register.
- lost_cnt  output  CNT_W  saturating count of lost requests.

Behaviour:
- Reset (async, rst=1): pend=0, Dout=0, Dvalid=0, lost_cnt=0, FSM=IDLE. Reset mid-handshake drops the grant and all pending requests with no acceptance.
- Pending update on each edge: pend_next = (pend & ~clr) | Din.
  - clr is one-hot at Dout when Dvalid & Dready, otherwise 0.
  - Set beats clear: if Din[Dout] is high in the accept cycle, that bit stays pending.
- Priority: the highest set index among eligible pend bits wins (MSB first). The eligible set is pend, or pend & ~mask when MASK_EN is defined.
- FSM state IDLE:
  - If the eligible set is non-zero: on the edge, Dout <= winner, Dvalid <= 1, go to GRANT.
  - Otherwise stay in IDLE with Dvalid=0 and Dout holding its last value.
- FSM state GRANT:
  - Dout and Dvalid are held stable; new requests or mask changes do not alter the held grant.
  - On an edge with Dready=1: clear pend[Dout] (subject to set-beats-clear), Dvalid <= 0, go to IDLE.
  - With Dready=0: stay in GRANT indefinitely.
- Latency and throughput:
  - Din pulse at edge E0 sets pend after E0; Dvalid=1 is visible after E1 (2 edges).
  - After acceptance there is a mandatory one-cycle Dvalid=0 bubble, so at most 1 grant per 2 cycles.
  - Dready is ignored while Dvalid=0.
- lost_cnt increments by 1 per edge on which (Din & pend & ~clr) != 0. This is one increment per edge regardless of how many bits collide. It saturates at 2^CNT_W-1 and never wraps; only rst clears it.
- Simultaneous new requests on several bits all latch; they are served in priority order over successive grants.
- A permanently asserted higher bit can starve lower bits. This is the intended strict-priority behaviour.

Optional Feature:
- Macro: PRIO_REQ_MASK_EN.
- Defined: adds input port mask [N-1:0]. Bits with mask=1 still latch into pend and count toward lost_cnt, but are excluded from selection until unmasked. Masking the bit currently held in GRANT does not revoke it.
- Undefined: no mask port; all pending bits are eligible.

Decomposition:
- Package prio_req_pkg holds:
  - typedef enum logic {IDLE, GRANT} prio_state_t;
  - function clog2_min1(n), returning at least 1 for the W calculation.
- Sub-module prio_find_msb (parameter N): purely combinational; input vec[N-1:0], outputs idx[W-1:0] and any.
  - Finds the highest set bit; idx=0 when vec=0.
  - Instantiated once on the eligible vector.

Test Plan:
- N=8, reset, then Din=8'b0010_0000 for 1 cycle, Dready=1 -> Dvalid rises 2 edges later with Dout=5, then drops next cycle; pending returns to 0.
- Din=8'b1000_0101 in one cycle, Dready=1 -> grants in order Dout=7, 2, 0, each separated by a 1-cycle bubble; lost_cnt=0.
- Dready=0 while Din pulses 8'b1000_0000 during a GRANT of index 3 -> Dout stays 3 until Dready=1; the next grant is 7.
- Pulse Din[4] three times while bit 4 is pending and unaccepted -> lost_cnt=3. With CNT_W=2 and 5 collisions -> lost_cnt saturates at 3.
- Accept index 6 on the same edge that Din[6]=1 -> pending[6] stays 1 and the next grant is 6 again.
- Assert rst asynchronously mid-GRANT with pend=8'hFF -> Dvalid, Dout, pending and lost_cnt go to 0 immediately, without waiting for clk. With PRIO_REQ_MASK_EN and mask=8'h80, pend=8'h81 -> the grant is 0.
